// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared op numbering, opcode/mode constants and FSM encoding
package instr_encoder_pkg;

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_MOV = 4'd1,
    OP_MVN = 4'd2,
    OP_ADD = 4'd3,
    OP_ADC = 4'd4,
    OP_SUB = 4'd5,
    OP_SBC = 4'd6,
    OP_AND = 4'd7,
    OP_ORR = 4'd8,
    OP_EOR = 4'd9,
    OP_CMP = 4'd10,
    OP_TST = 4'd11,
    OP_LDR = 4'd12,
    OP_STR = 4'd13,
    OP_B   = 4'd14,
    OP_ILL = 4'd15
  } op_e;

  localparam logic [3:0] DP_AND  = 4'b0000;
  localparam logic [3:0] DP_EOR  = 4'b0001;
  localparam logic [3:0] DP_SUB  = 4'b0010;
  localparam logic [3:0] DP_ADD  = 4'b0100;
  localparam logic [3:0] DP_ADC  = 4'b0101;
  localparam logic [3:0] DP_SBC  = 4'b0110;
  localparam logic [3:0] DP_TST  = 4'b1000;
  localparam logic [3:0] DP_CMP  = 4'b1010;
  localparam logic [3:0] DP_ORR  = 4'b1100;
  localparam logic [3:0] DP_MOV  = 4'b1101;
  localparam logic [3:0] DP_MVN  = 4'b1111;
  localparam logic [3:0] MEM_OPC = 4'b0100;

  localparam logic [1:0] MODE_DP  = 2'b00;
  localparam logic [1:0] MODE_MEM = 2'b01;
  localparam logic [1:0] MODE_BR  = 2'b10;
  localparam logic [1:0] MODE_NOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/instr_encoder_word_pack.sv
// instr_word_pack: combinational abstract-op to 32-bit instruction word encoder
module instr_word_pack
  import instr_encoder_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  cond,
  input  logic        s,
  input  logic        i,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [23:0] operand,
  output logic [31:0] word,
  output logic        illegal
);

  logic [3:0]  opc;
  logic        cmp_like;
  logic        mov_like;
  logic [31:0] dp_word;
  logic [31:0] mem_word;
  logic [31:0] br_word;

  // data-processing opcode lookup; non-DP ops fall through to AND and are unused
  always_comb begin
    opc = DP_AND;
    case (op)
      OP_MOV:  opc = DP_MOV;
      OP_MVN:  opc = DP_MVN;
      OP_ADD:  opc = DP_ADD;
      OP_ADC:  opc = DP_ADC;
      OP_SUB:  opc = DP_SUB;
      OP_SBC:  opc = DP_SBC;
      OP_ORR:  opc = DP_ORR;
      OP_EOR:  opc = DP_EOR;
      OP_CMP:  opc = DP_CMP;
      OP_TST:  opc = DP_TST;
      default: opc = DP_AND;
    endcase
  end

  // compares always set flags and have no destination; moves have no first operand
  assign cmp_like = (op == OP_CMP) || (op == OP_TST);
  assign mov_like = (op == OP_MOV) || (op == OP_MVN);
  assign dp_word  = {cond, MODE_DP, i, opc, s | cmp_like, mov_like ? 4'h0 : rn,
                     cmp_like ? 4'h0 : rd, operand[11:0]};
  assign mem_word = {cond, MODE_MEM, i, MEM_OPC, op == OP_LDR, rn, rd, operand[11:0]};
  assign br_word  = {cond, MODE_BR, 2'b10, operand};
  assign illegal  = op == OP_ILL;
  assign word     = (op == OP_NOP) ? {cond, MODE_NOP, 26'b0} :
                    (op == OP_LDR || op == OP_STR) ? mem_word :
                    (op == OP_B) ? br_word :
                    illegal ? 32'h0 : dp_word;

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: encodes one abstract op per handshake and writes it to imem at an auto-incrementing address
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic              req_i,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rd,
  input  logic [23:0]       req_operand,
  input  logic              clear,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  input  logic              imem_ready,
  output logic [ADDR_W:0]   word_count,
  output logic              full,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W:0]     cnt_q, cnt_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                err_q, err_d;
  logic [31:0]         word;
  logic                illegal;
  logic                accept;

  instr_word_pack u_pack (
    .op      (req_op),
    .cond    (req_cond),
    .s       (req_s),
    .i       (req_i),
    .rn      (req_rn),
    .rd      (req_rd),
    .operand (req_operand),
    .word    (word),
    .illegal (illegal)
  );

  assign req_ready = (state_q == ST_IDLE) && !clear;
  assign accept    = req_valid && req_ready;

  // next-state: clear dominates; illegal ops are acknowledged without writing
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    err_d   = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      ptr_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          err_d = illegal;
          if (!illegal) begin
            wdata_d = word;
            state_d = ST_WRITE;
          end
        end
        ST_WRITE: if (imem_ready) begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          state_d = (&ptr_q) ? ST_FULL : ST_IDLE;
        end
        ST_FULL: state_d = ST_FULL;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // state and datapath registers; reset aborts any in-flight write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign imem_we    = state_q == ST_WRITE;
  assign imem_addr  = ptr_q;
  assign imem_wdata = wdata_q;
  assign word_count = cnt_q;
  assign full       = state_q == ST_FULL;
  assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a behavioural model
module tb_instr_encoder;

  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
  localparam logic [3:0] DP_OPC [16] = '{4'h0, 4'hD, 4'hF, 4'h4, 4'h5, 4'h2, 4'h6, 4'h0,
                                         4'hC, 4'h1, 4'hA, 4'h8, 4'h0, 4'h0, 4'h0, 4'h0};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [3:0]    req_cond = '0;
  logic          req_s = 1'b0;
  logic          req_i = 1'b0;
  logic [3:0]    req_rn = '0;
  logic [3:0]    req_rd = '0;
  logic [23:0]   req_operand = '0;
  logic          clear = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          imem_ready = 1'b0;
  logic [AW:0]   word_count;
  logic          full;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_ptr = 0;
  int exp_cnt = 0;

  instr_encoder #(.ADDR_W(AW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_op      (req_op),
    .req_cond    (req_cond),
    .req_s       (req_s),
    .req_i       (req_i),
    .req_rn      (req_rn),
    .req_rd      (req_rd),
    .req_operand (req_operand),
    .clear       (clear),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .imem_ready  (imem_ready),
    .word_count  (word_count),
    .full        (full),
    .err         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, want);
    end
  endtask

  // instruction word built field by field with plain arithmetic
  function automatic logic [31:0] ref_word(input int op, input int cond, input int s, input int i,
                                           input int rn, input int rd, input int operand);
    int unsigned w;
    int unsigned sf, rnf, rdf;
    w = int'(cond) << 28;
    if (op == 0) return w + (3 << 26);
    if (op == 14) return w + (2 << 26) + (1 << 25) + operand;
    if (op == 15) return 0;
    if (op >= 12)
      return w + (1 << 26) + (i << 25) + (4 << 21) + (op == 12 ? (1 << 20) : 0)
             + (rn << 16) + (rd << 12) + (operand % 4096);
    sf  = (op == 10 || op == 11) ? 1 : s;
    rnf = (op == 1 || op == 2) ? 0 : rn;
    rdf = (op == 10 || op == 11) ? 0 : rd;
    return w + (i << 25) + (int'(DP_OPC[op]) << 21) + (sf << 20) + (rnf << 16) + (rdf << 12)
           + (operand % 4096);
  endfunction

  // one request from a negedge; stall = imem_ready-low cycles, abort = clear during write
  task automatic send(input int op, input int cond, input int s, input int i, input int rn,
                      input int rd, input int operand, input logic [31:0] want,
                      input int stall, input bit abort);
    req_valid   = 1'b1;
    req_op      = 4'(op);
    req_cond    = 4'(cond);
    req_s       = 1'(s);
    req_i       = 1'(i);
    req_rn      = 4'(rn);
    req_rd      = 4'(rd);
    req_operand = 24'(operand);
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_cnt != DEPTH));
    @(negedge clk);
    req_valid = 1'b0;
    if (exp_cnt == DEPTH) begin
      chk("full_hold", 32'(full), 32'd1);
      chk("full_no_we", 32'(imem_we), 32'd0);
      return;
    end
    if (op == 15) begin
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_we", 32'(imem_we), 32'd0);
      chk("ill_addr", 32'(imem_addr), 32'(exp_ptr));
      @(negedge clk);
      chk("ill_err_pulse", 32'(err), 32'd0);
      return;
    end
    chk("we", 32'(imem_we), 32'd1);
    chk("addr", 32'(imem_addr), 32'(exp_ptr));
    chk("wdata", imem_wdata, want);
    chk("busy_ready", 32'(req_ready), 32'd0);
    if (abort) begin
      clear      = 1'b1;
      imem_ready = 1'b1;
      @(negedge clk);
      clear      = 1'b0;
      imem_ready = 1'b0;
      exp_ptr    = 0;
      exp_cnt    = 0;
      chk("abort_cnt", 32'(word_count), 32'd0);
      chk("abort_we", 32'(imem_we), 32'd0);
      chk("abort_addr", 32'(imem_addr), 32'd0);
      return;
    end
    repeat (stall) begin
      @(negedge clk);
      chk("stall_we", 32'(imem_we), 32'd1);
      chk("stall_addr", 32'(imem_addr), 32'(exp_ptr));
      chk("stall_wdata", imem_wdata, want);
      chk("stall_ready", 32'(req_ready), 32'd0);
    end
    imem_ready = 1'b1;
    @(negedge clk);
    imem_ready = 1'b0;
    exp_ptr    = (exp_ptr + 1) % DEPTH;
    exp_cnt++;
    chk("count", 32'(word_count), 32'(exp_cnt));
    chk("full", 32'(full), 32'(exp_cnt == DEPTH));
    chk("post_we", 32'(imem_we), 32'd0);
    chk("post_addr", 32'(imem_addr), 32'(exp_ptr));
  endtask

  task automatic do_clear();
    clear = 1'b1;
    #1;
    chk("clear_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    clear   = 1'b0;
    exp_ptr = 0;
    exp_cnt = 0;
    chk("clear_cnt", 32'(word_count), 32'd0);
    chk("clear_full", 32'(full), 32'd0);
    chk("clear_we", 32'(imem_we), 32'd0);
    chk("clear_addr", 32'(imem_addr), 32'd0);
  endtask

  initial begin
    int op, stall;
    bit abort;
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_we", 32'(imem_we), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);
    chk("rst_wdata", imem_wdata, 32'd0);
    chk("rst_cnt", 32'(word_count), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    send(3, 14, 0, 1, 1, 2, 'h005, 32'hE2812005, 0, 1'b0);
    send(10, 14, 0, 0, 3, 7, 'h004, 32'hE1530004, 0, 1'b0);
    send(12, 14, 0, 0, 0, 1, 'h008, 32'hE4901008, 0, 1'b0);
    send(13, 14, 0, 0, 0, 1, 'h008, 32'hE4801008, 0, 1'b0);
    send(14, 14, 0, 0, 0, 0, 'hFFFFFE, 32'hEAFFFFFE, 0, 1'b0);
    send(15, 14, 0, 0, 0, 0, 0, 32'h0, 0, 1'b0);
    send(3, 14, 1, 0, 4, 5, 'h123, ref_word(3, 14, 1, 0, 4, 5, 'h123), 3, 1'b0);
    while (exp_cnt < DEPTH) send(0, 14, 0, 0, 0, 0, 0, 32'hEC000000, 0, 1'b0);
    send(0, 14, 0, 0, 0, 0, 0, 32'hEC000000, 0, 1'b0);
    do_clear();
    send(1, 14, 0, 0, 9, 3, 'h0FF, ref_word(1, 14, 0, 0, 9, 3, 'h0FF), 0, 1'b1);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 29) == 0) do_clear();
      op    = int'($urandom_range(0, 15));
      stall = int'($urandom_range(0, 2));
      abort = $urandom_range(0, 24) == 0;
      begin
        int cond, s, i, rn, rd, operand;
        cond    = int'($urandom_range(0, 15));
        s       = int'($urandom_range(0, 1));
        i       = int'($urandom_range(0, 1));
        rn      = int'($urandom_range(0, 15));
        rd      = int'($urandom_range(0, 15));
        operand = int'($urandom_range(0, 24'hFFFFFF));
        send(op, cond, s, i, rn, rd, operand, ref_word(op, cond, s, i, rn, rd, operand), stall, abort);
      end
    end
    do_clear();
    req_valid = 1'b1;
    req_op    = 4'd3;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    chk("arst_we", 32'(imem_we), 32'd0);
    chk("arst_cnt", 32'(word_count), 32'd0);
    chk("arst_addr", 32'(imem_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
